// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller: valid/ready request in, one quotient bit per enabled cycle,
// full-width quotient/remainder out on a valid/ready response. Define DIV_EARLY_TERM_EN to finish at once when dividend < divisor.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dbz_q, dbz_d;
  logic             req_ready_q, rsp_valid_q, busy_q;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   trial;

  // Remainder accumulator shifted left, pulling in the next dividend bit from the quotient register
  assign acc_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = acc_sh - {1'b0, dvsr_q};

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (dividend < divisor) begin
            quo_d   = '0;
            rem_d   = dividend;
            state_d = ST_DONE;
          end
`endif
          else begin
            quo_d   = dividend;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            dvsr_d  = divisor;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A clear sign bit means the trial subtraction fits; otherwise keep the shifted accumulator
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = acc_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          dbz_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags; ena=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      dbz_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      dbz_q       <= dbz_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign busy        = busy_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
